fetch_pipe: RTL and testbench

- Y86-64 pipeline fetch stage, directly downstream of the PC-select logic.
- Holds the F pipeline register (F_predPC), which is fed back to PC select.
- Each cycle: takes the selected PC, reads instruction bytes from an internal byte-addressable instruction memory, decodes the instruction length, predicts the next PC, and loads the D pipeline register.
- Honours stall and bubble requests from pipeline control.

---
 rtl/fetch_pipe.sv | 163 ++++++++++++++++
 tb/tb_fetch_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pipe.sv
// Y86-64 fetch stage: instruction memory, length/field decode, next-PC
// prediction, and the F (predicted PC) and D pipeline registers.
module fetch_pipe #(
   parameter int          MEM_BYTES = 1024,
   parameter logic [63:0] RESET_PC  = 64'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] PC_new,
   input  logic        F_stall,
   input  logic        D_stall,
   input  logic        D_bubble,
   input  logic        imem_we,
   input  logic [63:0] imem_waddr,
   input  logic [7:0]  imem_wdata,
   output logic [63:0] F_predPC,
   output logic [3:0]  D_stat,
   output logic [3:0]  D_icode,
   output logic [3:0]  D_ifun,
   output logic [3:0]  D_rA,
   output logic [3:0]  D_rB,
   output logic [63:0] D_valC,
   output logic [63:0] D_valP
);

   localparam int          AW      = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
   localparam logic [64:0] MEM_LIM = 65'(MEM_BYTES);

   localparam logic [3:0] S_AOK = 4'd1;
   localparam logic [3:0] S_HLT = 4'd2;
   localparam logic [3:0] S_ADR = 4'd3;
   localparam logic [3:0] S_INS = 4'd4;

   localparam logic [3:0] I_HALT = 4'h0;
   localparam logic [3:0] I_NOP  = 4'h1;
   localparam logic [3:0] R_NONE = 4'hF;

   logic [7:0]  mem [MEM_BYTES];

   logic [63:0] baddr_p0 [10];
   logic [7:0]  fb_p0 [10];
   logic [3:0]  raw_icode_p0;
   logic [3:0]  len_p0;
   logic [64:0] last_p0;
   logic        adr_p0;
   logic [3:0]  stat_p0;
   logic [3:0]  icode_p0;
   logic [3:0]  ifun_p0;
   logic [3:0]  ra_p0;
   logic [3:0]  rb_p0;
   logic [63:0] valc_p0;
   logic [63:0] valp_p0;
   logic [63:0] pred_p0;

   function automatic logic [3:0] instr_len(input logic [3:0] ic);
      case (ic)
         4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
         4'h7, 4'h8:             instr_len = 4'd9;
         4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
         default:                instr_len = 4'd1;
      endcase
   endfunction

   function automatic logic has_regs(input logic [3:0] ic);
      case (ic)
         4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_regs = 1'b1;
         default:                                  has_regs = 1'b0;
      endcase
   endfunction

   // Writes land at the edge, so a same-cycle read still sees the old byte.
   always_ff @(posedge clk) begin
      if (imem_we && ({1'b0, imem_waddr} < MEM_LIM))
         mem[imem_waddr[AW-1:0]] <= imem_wdata;
   end

   // Stage p0: combinational fetch and decode from PC_new
   always_comb begin
      for (int i = 0; i < 10; i++) begin
         baddr_p0[i] = PC_new + 64'(i);
         fb_p0[i]    = ({1'b0, baddr_p0[i]} < MEM_LIM) ? mem[baddr_p0[i][AW-1:0]] : 8'h00;
      end
   end

   always_comb begin
      raw_icode_p0 = fb_p0[0][7:4];
      ifun_p0      = fb_p0[0][3:0];
      icode_p0     = raw_icode_p0;
      len_p0       = instr_len(raw_icode_p0);
      ra_p0        = R_NONE;
      rb_p0        = R_NONE;
      valc_p0      = 64'd0;
      valp_p0      = PC_new + 64'(len_p0);

      if (has_regs(raw_icode_p0)) begin
         ra_p0 = fb_p0[1][7:4];
         rb_p0 = fb_p0[1][3:0];
      end

      case (raw_icode_p0)
         4'h3, 4'h4, 4'h5: valc_p0 = {fb_p0[9], fb_p0[8], fb_p0[7], fb_p0[6],
                                      fb_p0[5], fb_p0[4], fb_p0[3], fb_p0[2]};
         4'h7, 4'h8:       valc_p0 = {fb_p0[8], fb_p0[7], fb_p0[6], fb_p0[5],
                                      fb_p0[4], fb_p0[3], fb_p0[2], fb_p0[1]};
         default:          valc_p0 = 64'd0;
      endcase

      // 65-bit sum so an instruction straddling 2^64 still counts as out of range
      last_p0 = {1'b0, PC_new} + 65'(len_p0) - 65'd1;
      adr_p0  = ({1'b0, PC_new} >= MEM_LIM) || (last_p0 >= MEM_LIM);

      if (adr_p0)                    stat_p0 = S_ADR;
      else if (raw_icode_p0 > 4'hB)  stat_p0 = S_INS;
      else if (raw_icode_p0 == I_HALT) stat_p0 = S_HLT;
      else                           stat_p0 = S_AOK;

      if (stat_p0 == S_ADR || stat_p0 == S_INS) begin
         icode_p0 = I_NOP;
         ifun_p0  = 4'h0;
         ra_p0    = R_NONE;
         rb_p0    = R_NONE;
         valc_p0  = 64'd0;
         valp_p0  = PC_new;
      end

      // Any non-AOK status freezes fetch at the faulting PC
      if (stat_p0 != S_AOK)
         pred_p0 = PC_new;
      else if (raw_icode_p0 == 4'h7 || raw_icode_p0 == 4'h8)
         pred_p0 = valc_p0;
      else
         pred_p0 = valp_p0;
   end

   // Stage p1: F and D pipeline registers
   always_ff @(posedge clk) begin
      if (rst)
         F_predPC <= RESET_PC;
      else if (!F_stall)
         F_predPC <= pred_p0;
   end

   always_ff @(posedge clk) begin
      if (rst || (!D_stall && D_bubble)) begin
         D_stat  <= S_AOK;
         D_icode <= I_NOP;
         D_ifun  <= 4'h0;
         D_rA    <= R_NONE;
         D_rB    <= R_NONE;
         D_valC  <= 64'd0;
         D_valP  <= 64'd0;
      end else if (!D_stall) begin
         D_stat  <= stat_p0;
         D_icode <= icode_p0;
         D_ifun  <= ifun_p0;
         D_rA    <= ra_p0;
         D_rB    <= rb_p0;
         D_valC  <= valc_p0;
         D_valP  <= valp_p0;
      end
   end

endmodule

// File: tb/tb_fetch_pipe.sv
// Randomized scoreboard bench for fetch_pipe against an instruction-level
// reference model of Y86-64 fetch.
module tb_fetch_pipe;

   localparam int MEM = 1024;

   typedef struct packed {
      logic [3:0]  stat;
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [63:0] valc;
      logic [63:0] valp;
      logic [63:0] fpc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] PC_new = 64'd0;
   logic        F_stall = 1'b0, D_stall = 1'b0, D_bubble = 1'b0;
   logic        imem_we = 1'b0;
   logic [63:0] imem_waddr = 64'd0;
   logic [7:0]  imem_wdata = 8'd0;
   logic [63:0] F_predPC;
   logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
   logic [63:0] D_valC, D_valP;

   fetch_pipe #(.MEM_BYTES(MEM), .RESET_PC(64'd0)) dut (
      .clk(clk), .rst(rst), .PC_new(PC_new),
      .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
      .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .F_predPC(F_predPC), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
      .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   exp_t  exp_q[$];
   string tag_q[$];

   // Reference state
   logic [7:0]  mem_m [MEM];
   exp_t        m_d;
   logic [63:0] m_f = 64'd0;

   int len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};

   function automatic logic [7:0] rd(input logic [63:0] a);
      if (a < 64'(MEM)) return mem_m[int'(a)];
      return 8'h00;
   endfunction

   function automatic exp_t bubble();
      exp_t b;
      b = '0;
      b.stat = 4'd1; b.icode = 4'd1; b.ifun = 4'd0; b.ra = 4'hF; b.rb = 4'hF;
      return b;
   endfunction

   // Returns decoded D fields; .fpc carries the predicted next PC.
   function automatic exp_t decode(input logic [63:0] pc);
      exp_t        e;
      logic [7:0]  b0, b1;
      int          ic, len, off;
      logic        adr;
      e  = '0;
      b0 = rd(pc);
      ic = int'(b0[7:4]);
      len = len_tab[ic];
      adr = (pc >= 64'(MEM)) || ((64'(MEM) - pc) < 64'(len));
      e.icode = b0[7:4];
      e.ifun  = b0[3:0];
      e.ra = 4'hF; e.rb = 4'hF;
      if (ic inside {2, 3, 4, 5, 6, 10, 11}) begin
         b1 = rd(pc + 64'd1);
         e.ra = b1[7:4];
         e.rb = b1[3:0];
      end
      off = (ic inside {3, 4, 5}) ? 2 : (ic inside {7, 8}) ? 1 : 0;
      if (off != 0)
         for (int k = 0; k < 8; k++)
            e.valc = e.valc | (64'(rd(pc + 64'(off + k))) << (8 * k));
      e.valp = pc + 64'(len);
      if (adr)          e.stat = 4'd3;
      else if (ic > 11) e.stat = 4'd4;
      else if (ic == 0) e.stat = 4'd2;
      else              e.stat = 4'd1;
      if (e.stat == 4'd3 || e.stat == 4'd4) begin
         e.icode = 4'd1; e.ifun = 4'd0; e.ra = 4'hF; e.rb = 4'hF;
         e.valc = 64'd0; e.valp = pc;
      end
      if (e.stat != 4'd1)      e.fpc = pc;
      else if (ic inside {7, 8}) e.fpc = e.valc;
      else                     e.fpc = e.valp;
      return e;
   endfunction

   // One clock of stimulus; the reference result for the coming edge is queued.
   task automatic step(input logic [63:0] pc, input logic fs, input logic ds,
                       input logic db, input logic r, input logic we,
                       input logic [63:0] wa, input logic [7:0] wd, input string tag);
      exp_t dec, e;
      @(negedge clk);
      PC_new = pc; F_stall = fs; D_stall = ds; D_bubble = db; rst = r;
      imem_we = we; imem_waddr = wa; imem_wdata = wd;
      dec = decode(pc);
      if (r) begin
         m_f = 64'd0;
         m_d = bubble();
      end else begin
         if (!fs) m_f = dec.fpc;
         if (!ds) m_d = db ? bubble() : dec;
      end
      if (we && wa < 64'(MEM)) mem_m[int'(wa)] = wd;
      e = m_d;
      e.fpc = m_f;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic wr(input logic [63:0] a, input logic [7:0] d);
      step(64'd512, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, a, d, "load");
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, act, req);
      end
   endtask

   // Monitor: the D/F registers present a new result after every edge
   always @(posedge clk) begin
      exp_t  e, a;
      string t;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         a = {D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, F_predPC};
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL sb_%s t=%0t got stat=%0h ic=%0h fn=%0h rA=%0h rB=%0h valC=%0h valP=%0h F=%0h expected stat=%0h ic=%0h fn=%0h rA=%0h rB=%0h valC=%0h valP=%0h F=%0h",
                     t, $time, a.stat, a.icode, a.ifun, a.ra, a.rb, a.valc, a.valp, a.fpc,
                     e.stat, e.icode, e.ifun, e.ra, e.rb, e.valc, e.valp, e.fpc);
         end
      end
   end

   initial begin
      logic [7:0] irm [10];
      logic [7:0] jmp [9];
      logic [63:0] pc, wa;
      int sel;
      irm = '{8'h30, 8'hF2, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      jmp = '{8'h70, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      m_d = bubble();

      // Reset held while every memory byte is given a known value
      for (int i = 0; i < MEM; i++)
         step(64'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'(i), 8'($urandom), "reset_load");
      step(64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 8'd0, "reset");
      @(posedge clk); #2;
      chk("reset_F", F_predPC, 64'd0);
      chk("reset_stat", 64'(D_stat), 64'd1);
      chk("reset_icode", 64'(D_icode), 64'd1);
      chk("reset_rArB", 64'({D_rA, D_rB}), 64'hFF);
      chk("reset_valP", D_valP, 64'd0);

      for (int i = 0; i < 10; i++) wr(64'(i), irm[i]);
      for (int i = 0; i < 9; i++)  wr(64'(10 + i), jmp[i]);

      step(64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 8'd0, "irmovq");
      @(posedge clk); #2;
      chk("irmovq_fields", 64'({D_stat, D_icode, D_ifun, D_rA, D_rB}), 64'h13_0F2);
      chk("irmovq_valC", D_valC, 64'd8);
      chk("irmovq_valP", D_valP, 64'd10);
      chk("irmovq_F", F_predPC, 64'd10);

      step(64'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 8'd0, "jmp");
      @(posedge clk); #2;
      chk("jmp_icode", 64'(D_icode), 64'd7);
      chk("jmp_valC", D_valC, 64'h40);
      chk("jmp_valP", D_valP, 64'd19);
      chk("jmp_F", F_predPC, 64'h40);

      step(64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 8'd0, "irmovq2");
      step(64'd10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 8'd0, "stall_bubble");
      @(posedge clk); #2;
      chk("stall_wins_icode", 64'(D_icode), 64'd3);
      chk("stall_wins_valP", D_valP, 64'd10);
      step(64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 8'd0, "bubble");
      @(posedge clk); #2;
      chk("bubble_icode", 64'(D_icode), 64'd1);
      chk("bubble_stat", 64'(D_stat), 64'd1);
      chk("bubble_F", F_predPC, 64'd10);
      step(64'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 8'd0, "fstall");
      @(posedge clk); #2;
      chk("fstall_F", F_predPC, 64'd10);

      wr(64'd1020, 8'h30);
      step(64'd1020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 8'd0, "adr");
      @(posedge clk); #2;
      chk("adr_stat", 64'(D_stat), 64'd3);
      chk("adr_icode", 64'(D_icode), 64'd1);
      chk("adr_valP", D_valP, 64'd1020);
      chk("adr_F", F_predPC, 64'd1020);

      wr(64'd0, 8'hC0);
      step(64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 8'd0, "ins");
      @(posedge clk); #2;
      chk("ins_stat", 64'(D_stat), 64'd4);
      chk("ins_F", F_predPC, 64'd0);

      wr(64'd0, 8'h00);
      step(64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 8'd0, "hlt");
      @(posedge clk); #2;
      chk("hlt_stat", 64'(D_stat), 64'd2);
      chk("hlt_valP", D_valP, 64'd1);
      chk("hlt_F", F_predPC, 64'd0);

      // Write to a byte read in the same cycle must not be seen until later
      step(64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 8'h10, "rdw_old");
      step(64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 8'd0, "rdw_new");

      for (int n = 0; n < 4000; n++) begin
         sel = int'($urandom_range(0, 9));
         case (sel)
            6:       pc = 64'($urandom_range(1005, 1030));
            7, 8:    pc = m_f;
            9:       pc = ($urandom_range(0, 1) != 0) ? (64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15)))
                                                      : {32'($urandom), 32'($urandom)};
            default: pc = 64'($urandom_range(0, MEM - 1));
         endcase
         case ($urandom_range(0, 7))
            0:       wa = 64'($urandom_range(MEM, MEM + 64));
            1:       wa = {32'($urandom), 32'($urandom)};
            default: wa = 64'($urandom_range(0, MEM - 1));
         endcase
         step(pc, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0),
              ($urandom_range(0, 1) == 1), wa, 8'($urandom), "rand");
      end

      for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
